// File: rtl/priority_decoder_lsb_pkg.sv
// priority_decoder_lsb_pkg
// Shared helpers for the lowest-set-bit priority decoder.
// Contents:
//   idx_width(w) - width of a binary index able to address w requesters.
//   MIN_WIDTH    - smallest request vector the decoder supports.
package priority_decoder_lsb_pkg;

    localparam int MIN_WIDTH = 2;

    // Index width for a vector of w bits. It never drops below one bit,
    // so every index port always has a legal range.
    function automatic int idx_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/priority_decoder_lsb_lsb_find.sv
// lsb_find
// Purely combinational lowest-set-bit finder.
// Ports:
//   in     [WIDTH-1:0] request vector, bit 0 has the highest priority
//   idx    [IDX_W-1:0] index of the lowest set bit, 0 when in is zero
//   onehot [WIDTH-1:0] one-hot copy of the selected bit, 0 when in is zero
//   any                1 when any bit of in is set
module lsb_find
    import priority_decoder_lsb_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] in,
    output logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] onehot,
    output logic             any
);

    // The scan runs from the top bit down, so the last hit written is the
    // lowest-indexed set bit and overrides any higher ones.
    always_comb begin
        idx    = '0;
        onehot = '0;
        any    = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in[i]) begin
                idx       = IDX_W'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_decoder_lsb.sv
// priority_decoder_lsb
// Registered lowest-set-bit priority decoder with one-cycle latency.
// Ports:
//   clk    system clock, rising edge active
//   rst_n  synchronous active-low reset, clears all outputs
//   in     [WIDTH-1:0] request vector, bit 0 has the highest priority
//   out    [IDX_W-1:0] registered index of the lowest set bit of in
//   valid  registered flag, 1 when in was non-zero
//   onehot [WIDTH-1:0] registered one-hot copy of the selected bit
module priority_decoder_lsb
    import priority_decoder_lsb_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IDX_W = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [IDX_W-1:0] out,
    output logic             valid,
    output logic [WIDTH-1:0] onehot
);

    generate
        if (WIDTH < MIN_WIDTH) begin : g_width_check
            $error("priority_decoder_lsb: WIDTH must be at least 2");
        end
    endgenerate

    logic [IDX_W-1:0] find_idx;
    logic [WIDTH-1:0] find_onehot;
    logic             find_any;

    lsb_find #(
        .WIDTH (WIDTH)
    ) u_lsb_find (
        .in     (in),
        .idx    (find_idx),
        .onehot (find_onehot),
        .any    (find_any)
    );

    // The finder already returns index 0 for an empty vector, so an invalid
    // result forces out to zero rather than holding the previous index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out    <= '0;
            valid  <= 1'b0;
            onehot <= '0;
        end else begin
            out    <= find_idx;
            valid  <= find_any;
            onehot <= find_onehot;
        end
    end

endmodule

// File: tb/tb_priority_decoder_lsb.sv
// tb_priority_decoder_lsb
// Self-checking bench for priority_decoder_lsb at WIDTH 8, 5 and 2.
// Expected results are pushed to per-instance queues when a request is driven
// and popped one clock later, when the registered outputs hold the result.
module tb_priority_decoder_lsb;

    typedef struct {
        logic [7:0] out;
        logic       valid;
        logic [7:0] onehot;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] in8;
    logic [4:0] in5;
    logic [1:0] in2;
    logic [2:0] out8;
    logic [2:0] out5;
    logic [0:0] out2;
    logic       valid8, valid5, valid2;
    logic [7:0] onehot8;
    logic [4:0] onehot5;
    logic [1:0] onehot2;

    exp_t sb8[$];
    exp_t sb5[$];
    exp_t sb2[$];

    int checks;
    int passed;

    priority_decoder_lsb #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in(in8),
        .out(out8), .valid(valid8), .onehot(onehot8)
    );

    priority_decoder_lsb #(.WIDTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in(in5),
        .out(out5), .valid(valid5), .onehot(onehot5)
    );

    priority_decoder_lsb #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in(in2),
        .out(out2), .valid(valid2), .onehot(onehot2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: scan upward from bit 0 within the low w bits.
    function automatic exp_t ref_model(input logic [7:0] v, input int w);
        exp_t e;
        e.out    = 8'd0;
        e.valid  = 1'b0;
        e.onehot = 8'd0;
        for (int i = 0; i < w; i++) begin
            if (v[i] && !e.valid) begin
                e.out       = 8'(i);
                e.valid     = 1'b1;
                e.onehot[i] = 1'b1;
            end
        end
        return e;
    endfunction

    function automatic exp_t mk(input int o, input logic v, input logic [7:0] oh);
        exp_t e;
        e.out    = 8'(o);
        e.valid  = v;
        e.onehot = oh;
        return e;
    endfunction

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        in8   = 8'hFF;
        for (int c = 0; c < 2; c++) begin
            sb8.push_back(mk(0, 1'b0, 8'h00));
            @(posedge clk); #1;
            e = sb8.pop_front();
            checks++;
            if ({5'd0, out8, valid8, onehot8} !== {e.out, e.valid, e.onehot})
                $display("[TB] FAIL reset cycle %0d: out=%0d valid=%0b onehot=%h, want out=%0d valid=%0b onehot=%h",
                         c, out8, valid8, onehot8, e.out, e.valid, e.onehot);
            else passed++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_patterns();
        logic [7:0] stim[7];
        exp_t       want[7];
        exp_t       e;
        stim = '{8'h00, 8'h80, 8'h01, 8'h08, 8'h50, 8'h22, 8'hFF};
        want = '{mk(0, 1'b0, 8'h00), mk(7, 1'b1, 8'h80), mk(0, 1'b1, 8'h01),
                 mk(3, 1'b1, 8'h08), mk(4, 1'b1, 8'h10), mk(1, 1'b1, 8'h02),
                 mk(0, 1'b1, 8'h01)};
        for (int k = 0; k < 7; k++) begin
            in8 = stim[k];
            sb8.push_back(want[k]);
            @(posedge clk); #1;
            e = sb8.pop_front();
            checks++;
            if ({5'd0, out8, valid8, onehot8} !== {e.out, e.valid, e.onehot})
                $display("[TB] FAIL pattern in=%h: out=%0d valid=%0b onehot=%h, want out=%0d valid=%0b onehot=%h",
                         stim[k], out8, valid8, onehot8, e.out, e.valid, e.onehot);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] stim[3];
        exp_t       want[3];
        exp_t       e;
        stim = '{8'h80, 8'h00, 8'h06};
        want = '{mk(7, 1'b1, 8'h80), mk(0, 1'b0, 8'h00), mk(1, 1'b1, 8'h02)};
        for (int k = 0; k < 3; k++) begin
            in8 = stim[k];
            sb8.push_back(want[k]);
            @(posedge clk); #1;
            e = sb8.pop_front();
            checks++;
            if ({5'd0, out8, valid8, onehot8} !== {e.out, e.valid, e.onehot})
                $display("[TB] FAIL back_to_back step %0d: out=%0d valid=%0b onehot=%h, want out=%0d valid=%0b onehot=%h",
                         k, out8, valid8, onehot8, e.out, e.valid, e.onehot);
            else passed++;
        end
    endtask

    task automatic test_midstream_reset();
        exp_t e;
        in8 = 8'h10;
        rst_n = 1'b0;
        sb8.push_back(mk(0, 1'b0, 8'h00));
        @(posedge clk); #1;
        e = sb8.pop_front();
        checks++;
        if ({5'd0, out8, valid8, onehot8} !== {e.out, e.valid, e.onehot})
            $display("[TB] FAIL midreset held: out=%0d valid=%0b onehot=%h, want out=%0d valid=%0b onehot=%h",
                     out8, valid8, onehot8, e.out, e.valid, e.onehot);
        else passed++;
        rst_n = 1'b1;
        sb8.push_back(mk(4, 1'b1, 8'h10));
        @(posedge clk); #1;
        e = sb8.pop_front();
        checks++;
        if ({5'd0, out8, valid8, onehot8} !== {e.out, e.valid, e.onehot})
            $display("[TB] FAIL midreset release: out=%0d valid=%0b onehot=%h, want out=%0d valid=%0b onehot=%h",
                     out8, valid8, onehot8, e.out, e.valid, e.onehot);
        else passed++;
    endtask

    task automatic test_random();
        exp_t       e;
        logic [7:0] o8, oh8;
        for (int c = 0; c < 1000; c++) begin
            in8 = 8'($urandom);
            in5 = 5'($urandom);
            in2 = 2'($urandom);
            // Bias some cycles toward sparse and empty vectors.
            if (c % 7 == 0) in8 = in8 & 8'($urandom);
            if (c % 11 == 0) begin in8 = 8'h00; in5 = 5'h00; in2 = 2'h0; end
            sb8.push_back(ref_model(in8, 8));
            sb5.push_back(ref_model({3'd0, in5}, 5));
            sb2.push_back(ref_model({6'd0, in2}, 2));
            @(posedge clk); #1;

            e = sb8.pop_front();
            checks++;
            if ({5'd0, out8, valid8, onehot8} !== {e.out, e.valid, e.onehot})
                $display("[TB] FAIL random8 cycle %0d: out=%0d valid=%0b onehot=%h, want out=%0d valid=%0b onehot=%h",
                         c, out8, valid8, onehot8, e.out, e.valid, e.onehot);
            else passed++;

            e = sb5.pop_front();
            o8  = {5'd0, out5};
            oh8 = {3'd0, onehot5};
            checks++;
            if ({o8, valid5, oh8} !== {e.out, e.valid, e.onehot})
                $display("[TB] FAIL random5 cycle %0d: out=%0d valid=%0b onehot=%h, want out=%0d valid=%0b onehot=%h",
                         c, out5, valid5, onehot5, e.out, e.valid, e.onehot);
            else passed++;

            e = sb2.pop_front();
            o8  = {7'd0, out2};
            oh8 = {6'd0, onehot2};
            checks++;
            if ({o8, valid2, oh8} !== {e.out, e.valid, e.onehot})
                $display("[TB] FAIL random2 cycle %0d: out=%0d valid=%0b onehot=%h, want out=%0d valid=%0b onehot=%h",
                         c, out2, valid2, onehot2, e.out, e.valid, e.onehot);
            else passed++;

            // Structural invariants on the widest instance.
            checks++;
            if ($countones(onehot8) > 1)
                $display("[TB] FAIL invariant_onehot cycle %0d: onehot=%h, want at most one bit", c, onehot8);
            else passed++;
            checks++;
            if (valid8 !== (|onehot8))
                $display("[TB] FAIL invariant_valid cycle %0d: valid=%0b, want %0b", c, valid8, |onehot8);
            else passed++;
            checks++;
            if (valid8 && onehot8[out8] !== 1'b1)
                $display("[TB] FAIL invariant_index cycle %0d: onehot[%0d]=%0b, want 1", c, out8, onehot8[out8]);
            else passed++;
            checks++;
            if (valid5 !== (|onehot5) || $countones(onehot5) > 1)
                $display("[TB] FAIL invariant_w5 cycle %0d: valid=%0b onehot=%h, want consistent", c, valid5, onehot5);
            else passed++;
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst_n  = 1'b0;
        in8    = 8'h00;
        in5    = 5'h00;
        in2    = 2'h0;
        #1;
        test_reset();
        test_patterns();
        test_back_to_back();
        test_midstream_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/priority_decoder_lsb.md
# priority_decoder_lsb

Parameterised priority decoder: finds the lowest-indexed asserted bit of a request vector and reports its binary index, a one-hot grant and a valid flag. Bit 0 has the highest priority. Outputs are registered on the single system clock, so the block drops straight into pipelined arbitration and issue-select paths in the CPU.

## Interface

Parameters:
- WIDTH, default 8: request vector width; legal range 2..256, any value (power of two not required).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- in  input  WIDTH  request vector; bit i set means requester i active.
- out  output  $clog2(WIDTH)  binary index of lowest set bit of in.
- valid  output  1  1 when in was non-zero.
- onehot  output  WIDTH  one-hot copy of the selected bit (in & -in).

## Operation

- Priority: lowest index wins. For in = 8'b0101_0000, out = 4, not 6.
- in non-zero: valid=1, out = index of lowest set bit, onehot = 1 << out.
- in zero: valid=0, out=0, onehot=0. out is forced to 0 (not held) when invalid.
- Only the lowest set bit matters; all higher bits are ignored.
- Index arithmetic is unsigned, width $clog2(WIDTH). The maximum index WIDTH-1 always fits.
- Invariants on every cycle:
  - onehot has at most one bit set.
  - valid == |onehot.
  - If valid, onehot[out] == 1.

## Timing

- Fully pipelined, one-cycle latency: in sampled at rising edge N appears on out/valid/onehot after edge N.
- A new request is accepted every cycle. There is no handshake and no stall.
- Reset (rst_n=0 at a rising edge): out=0, valid=0, onehot=0. This overrides the in sampled on that edge.
- Reset mid-stream: the result of the request sampled with rst_n low is discarded. The first valid result appears one edge after rst_n returns high.
- No combinational path from in to any output.

## Structure

- No shared package needed. If the team keeps a common width helper, IDX_W = $clog2(WIDTH) belongs there.
- One natural sub-module, lsb_find:
  - Purely combinational, parameter WIDTH.
  - Produces the index, one-hot and any-set signals.
  - Implementation choice: log-depth tree or scan loop.
- Top level instantiates lsb_find and holds three output registers with synchronous active-low reset.
- Elaboration-time check: WIDTH >= 2.

## Test plan

WIDTH=8; each check is made one clock after the stimulus edge.
- Reset: hold rst_n=0 two cycles with in=8'hFF -> out=0, valid=0, onehot=0.
- Zero input: in=8'h00 -> valid=0, out=0, onehot=0.
- Single bits: in=8'b1000_0000 -> out=7; in=8'b0000_0001 -> out=0; in=8'b0000_1000 -> out=3. valid=1 and onehot=in in each case.
- Multiple bits: in=8'b0101_0000 -> out=4, onehot=8'b0001_0000; in=8'b0010_0010 -> out=1, onehot=8'b0000_0010; in=8'hFF -> out=0.
- Back-to-back: change in every cycle (8'h80, 8'h00, 8'h06) -> outputs track with exactly one-cycle lag: (7,1), (0,0), (1,1).
- Mid-stream reset: assert rst_n=0 for one edge while in=8'h10 -> outputs zero on that edge, out=4 one edge after release.
- Random: random in over 1000 cycles -> compare against a lowest-set-bit reference model and check the invariants.
- Repeat the random test at WIDTH=5 and WIDTH=2.
